// File: rtl/eda_output_reader.sv
// Streams a snapshot of the MxN regional-max flag matrix row-major over valid/ready,
// OUT_WIDTH flags per beat, and reports the count of set flags with a done pulse.
`ifndef CFG_M
  `define CFG_M 4
`endif
`ifndef CFG_N
  `define CFG_N 8
`endif
`ifndef CFG_I_WIDTH
  `define CFG_I_WIDTH 2
`endif

module eda_output_reader #(
  parameter  int M         = `CFG_M,
  parameter  int N         = `CFG_N,
  parameter  int I_WIDTH   = `CFG_I_WIDTH,
  parameter  int OUT_WIDTH = 8,
  localparam int BEATS     = (N + OUT_WIDTH - 1) / OUT_WIDTH,
  localparam int B_WIDTH   = (BEATS > 1) ? $clog2(BEATS) : 1,
  localparam int CNT_WIDTH = $clog2(M * N + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      start,
  input  logic [M-1:0][N-1:0]       matrix_in,
  input  logic                      out_ready,
  output logic                      out_valid,
  output logic [OUT_WIDTH-1:0]      out_data,
  output logic [I_WIDTH-1:0]        out_row,
  output logic [B_WIDTH-1:0]        out_beat,
  output logic                      out_last,
  output logic                      busy,
  output logic                      done,
  output logic [CNT_WIDTH-1:0]      max_count
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;

  localparam logic [I_WIDTH-1:0] LAST_ROW  = I_WIDTH'(M - 1);
  localparam logic [B_WIDTH-1:0] LAST_BEAT = B_WIDTH'(BEATS - 1);

  logic [1:0]               state;
  logic [M-1:0][N-1:0]      snap;
  logic [CNT_WIDTH-1:0]     acc;
  logic [CNT_WIDTH-1:0]     beat_ones;
  logic [I_WIDTH-1:0]       nxt_row;
  logic [B_WIDTH-1:0]       nxt_beat;
  logic [OUT_WIDTH-1:0]     nxt_data;
  logic                     hs;
  logic                     take;

  // Columns past N in a partial final beat read as zero.
  function automatic logic [OUT_WIDTH-1:0] slice_of(input logic [N-1:0] flags,
                                                    input logic [B_WIDTH-1:0] b);
    logic [OUT_WIDTH-1:0] r;
    r = '0;
    for (int k = 0; k < OUT_WIDTH; k++) begin
      if (int'(b) * OUT_WIDTH + k < N) r[k] = flags[int'(b) * OUT_WIDTH + k];
    end
    return r;
  endfunction

  assign hs        = out_valid & out_ready;
  assign take      = (state == IDLE) & start & ~reset & ~clear;
  assign beat_ones = CNT_WIDTH'($countones(out_data));

  always_comb begin
    nxt_row  = out_row;
    nxt_beat = out_beat + 1'b1;
    if (out_beat == LAST_BEAT) begin
      nxt_beat = '0;
      nxt_row  = out_row + 1'b1;
    end
    nxt_data = slice_of(snap[nxt_row], nxt_beat);
  end

  always_ff @(posedge clk) begin
    if (take) snap <= matrix_in;
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_row   <= '0;
      out_beat  <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      max_count <= '0;
      acc       <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            out_row   <= '0;
            out_beat  <= '0;
            out_data  <= slice_of(matrix_in[0], '0);
            out_last  <= (M == 1) && (BEATS == 1);
            out_valid <= 1'b1;
            busy      <= 1'b1;
            acc       <= '0;
            state     <= SEND;
          end
        end
        SEND: begin
          if (hs) begin
            acc <= acc + beat_ones;
            if (out_last) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              out_data  <= '0;
              out_row   <= '0;
              out_beat  <= '0;
              busy      <= 1'b0;
              done      <= 1'b1;
              max_count <= acc + beat_ones;
              state     <= FIN;
            end else begin
              out_row  <= nxt_row;
              out_beat <= nxt_beat;
              out_data <= nxt_data;
              out_last <= (nxt_row == LAST_ROW) && (nxt_beat == LAST_BEAT);
            end
          end
        end
        FIN: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eda_output_reader.sv
// Randomized scoreboard bench for eda_output_reader: frames are modelled as flat flag
// arrays, expected beats/counts queued at issue and checked by a negedge monitor.
module tb_eda_output_reader;
  localparam int M = 4, N = 6, OW = 4, IW = 2;
  localparam int BEATS = (N + OW - 1) / OW;
  localparam int BW = 1, CW = 5;

  logic clk = 1'b0;
  logic reset = 1'b1, clear = 1'b0, start = 1'b0;
  logic out_ready = 1'b0;
  logic [M-1:0][N-1:0] matrix_in = '0;
  logic out_valid, out_last, busy, done;
  logic [OW-1:0] out_data;
  logic [IW-1:0] out_row;
  logic [BW-1:0] out_beat;
  logic [CW-1:0] max_count;

  eda_output_reader #(.M(M), .N(N), .I_WIDTH(IW), .OUT_WIDTH(OW)) dut (
    .clk(clk), .reset(reset), .clear(clear), .start(start), .matrix_in(matrix_in),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data), .out_row(out_row),
    .out_beat(out_beat), .out_last(out_last), .busy(busy), .done(done), .max_count(max_count)
  );

  always #5 clk = ~clk;

  typedef struct {int row; int beat; logic [OW-1:0] data; logic last;} beat_t;
  beat_t exp_q[$];
  int    done_q[$];
  int    checks = 0, errors = 0, hs_cnt = 0;
  int    ready_mode = 1;  // 0 low, 1 high, 2 toggle, 3 random

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      2:       out_ready = ~out_ready;
      default: out_ready = 1'($urandom % 2);
    endcase
  end

  // Monitor: handshakes pop expected beats, done pops the expected count.
  logic st_prev = 1'b0, st_last;
  logic [OW-1:0] st_d;
  logic [IW-1:0] st_r;
  logic [BW-1:0] st_b;
  beat_t e;
  always @(negedge clk) begin
    if (reset || clear) st_prev = 1'b0;
    else begin
      if (st_prev) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, st_d);
        chk("stall_row", out_row, st_r);
        chk("stall_beat", out_beat, st_b);
        chk("stall_last", out_last, st_last);
      end
      st_prev = 1'b0;
      if (out_valid && out_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL beat_unexpected actual=row%0d/beat%0d required=none", out_row, out_beat);
        end else begin
          e = exp_q.pop_front();
          chk("beat_row", out_row, e.row);
          chk("beat_idx", out_beat, e.beat);
          chk("beat_data", out_data, e.data);
          chk("beat_last", out_last, e.last);
        end
      end else if (out_valid) begin
        st_prev = 1'b1; st_d = out_data; st_r = out_row; st_b = out_beat; st_last = out_last;
      end
      if (done) begin
        if (done_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL done_unexpected actual=done required=none");
        end else chk("max_count", max_count, done_q.pop_front());
        chk("busy_at_done", busy, 0);
      end
    end
  end

  task automatic push_frame(input logic [M-1:0][N-1:0] mat);
    int cnt = 0;
    for (int r = 0; r < M; r++)
      for (int b = 0; b < BEATS; b++) begin
        beat_t x;
        x.row = r; x.beat = b; x.data = '0;
        for (int k = 0; k < OW; k++)
          if (b * OW + k < N) x.data[k] = mat[r][b * OW + k];
        x.last = (r == M - 1) && (b == BEATS - 1);
        exp_q.push_back(x);
      end
    for (int r = 0; r < M; r++)
      for (int c = 0; c < N; c++) cnt += int'(mat[r][c]);
    done_q.push_back(cnt);
  endtask

  task automatic pulse_start(input logic [M-1:0][N-1:0] mat, input int scramble);
    @(posedge clk); #1 matrix_in = mat; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    if (scramble == 1) matrix_in = '0;
    else if (scramble == 2) matrix_in = (M * N)'($urandom);
    @(negedge clk);
    chk("start_valid", out_valid, 1);
    chk("start_busy", busy, 1);
  endtask

  task automatic run_frame(input logic [M-1:0][N-1:0] mat, input int mode, input int scramble,
                           input bit noise, input bit fin_start);
    bit got = 1'b0;
    int lat = 0;
    ready_mode = mode;
    push_frame(mat);
    pulse_start(mat, scramble);
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (done) begin got = 1'b1; lat = i; break; end
      start = noise && busy && ($urandom % 4 == 0);
    end
    if (!got) begin
      checks++; errors++; start = 1'b0;
      $display("FAIL done_timeout actual=none required=done");
    end else begin
      if (mode == 1) chk("throughput", lat, M * BEATS - 1);
      start = fin_start;
    end
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk("idle_valid", out_valid, 0);
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
    chk("beats_left", exp_q.size(), 0);
  endtask

  task automatic clear_frame(input logic [M-1:0][N-1:0] mat);
    int base = hs_cnt;
    ready_mode = 1;
    push_frame(mat);
    pulse_start(mat, 0);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #2;
      if (hs_cnt >= base + 3) break;
    end
    ready_mode = 0;
    @(posedge clk); #1 clear = 1'b1; start = 1'b1;
    @(posedge clk); #1 clear = 1'b0; start = 1'b0;
    exp_q.delete();
    void'(done_q.pop_back());
    @(negedge clk);
    chk("clear_valid", out_valid, 0);
    chk("clear_busy", busy, 0);
    chk("clear_max", max_count, 0);
    chk("clear_done", done, 0);
    chk("clear_beats", hs_cnt - base, 3);
    repeat (5) @(negedge clk);
    chk("clear_start_ignored", out_valid, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    logic [M-1:0][N-1:0] ones, diag, m;
    ones = '1;
    diag = '0;
    for (int i = 0; i < M; i++) diag[i][i] = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_row", out_row, 0);
    chk("rst_beat", out_beat, 0);
    chk("rst_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_max", max_count, 0);

    run_frame(ones, 1, 1, 0, 0);   // all ones, snapshot isolation
    run_frame(diag, 1, 0, 0, 0);   // diagonal
    run_frame(ones, 2, 0, 0, 0);   // toggled backpressure
    run_frame(diag, 3, 2, 1, 1);   // random ready, stray starts, start in FIN
    clear_frame(ones);
    run_frame(ones, 1, 0, 0, 0);
    for (int t = 0; t < 12; t++) begin
      m = (M * N)'($urandom);
      run_frame(m, 1 + int'($urandom % 3), 2, 1'($urandom % 2), 1'($urandom % 2));
    end
    repeat (3) @(negedge clk);
    chk("final_beats_left", exp_q.size(), 0);
    chk("final_done_left", done_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
